// File: rtl/cdc_pulse_sync_mc_if.sv
// Pulse-synchroniser port bundle: clk_a-side event/clear inputs, clk_b pulses and clk_a status.
`timescale 1ns/1ps
interface cdc_pulse_sync_mc_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] imp_a;
  logic [CHANNELS-1:0] ovf_clr;
  logic [CHANNELS-1:0] imp_b;
  logic [CHANNELS-1:0] busy_a;
  logic [CHANNELS-1:0] ovf_a;

  modport master (
    output imp_a,
    output ovf_clr,
    input  imp_b,
    input  busy_a,
    input  ovf_a
  );

  modport slave (
    input  imp_a,
    input  ovf_clr,
    output imp_b,
    output busy_a,
    output ovf_a
  );
endinterface

// File: rtl/cdc_pulse_sync_mc.sv
// Multi-channel toggle-handshake pulse synchroniser clk_a -> clk_b with per-channel pending queue.
// Optional macro CDC_PULSE_DROP_ON_BUSY_EN: no queue, pulses arriving while busy are dropped.
`timescale 1ns/1ps
module cdc_pulse_sync_mc #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  clk_b,
  cdc_pulse_sync_mc_if.slave    bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [CHANNELS-1:0] req_t;
  logic [CHANNELS-1:0] ack_t;
  logic [CHANNELS-1:0] busy_vec;
  logic [CHANNELS-1:0] ovf_vec;
  logic [CHANNELS-1:0] imp_b_vec;

  // clk_b reset: asserts with rst, releases after two clk_b edges
  logic [1:0] rst_b_sync_q;
  logic       rst_b;

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) rst_b_sync_q <= 2'b00;
    else     rst_b_sync_q <= {rst_b_sync_q[0], 1'b1};
  end

  assign rst_b = ~rst_b_sync_q[1];

  for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : g_ch
    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   ovf_q, ovf_d;
    logic                   ovf_set;
    logic                   launch;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   prev_q;
    logic                   imp_b_q;

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    // ack_t back into clk_a
    always_ff @(posedge clk_a or posedge rst) begin
      if (rst) ack_sync_q <= '0;
      else     ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_t[ch]};
    end

`ifdef CDC_PULSE_DROP_ON_BUSY_EN
    always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      ovf_set = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.imp_a[ch]) begin
            launch  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          ovf_set = bus.imp_a[ch];
          if (ack_sync == req_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      req_d = req_q ^ launch;
      ovf_d = ovf_set ? 1'b1 : (bus.ovf_clr[ch] ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_a or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
        ovf_q   <= ovf_d;
      end
    end
`else
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CNT_W-1:0] pend_q, pend_d;

    always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      launch  = 1'b0;
      ovf_set = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.imp_a[ch] || (pend_q != '0)) begin
            launch  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_sync == req_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // pend + imp_a - launch; a full queue drops the pulse instead
      if (bus.imp_a[ch] && !launch) begin
        if (pend_q == PEND_MAX) ovf_set = 1'b1;
        else                    pend_d  = pend_q + CNT_W'(1);
      end else if (!bus.imp_a[ch] && launch) begin
        pend_d = pend_q - CNT_W'(1);
      end
      req_d = req_q ^ launch;
      ovf_d = ovf_set ? 1'b1 : (bus.ovf_clr[ch] ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_a or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        ovf_q   <= 1'b0;
        pend_q  <= '0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
        ovf_q   <= ovf_d;
        pend_q  <= pend_d;
      end
    end
`endif

    // clk_b: sync the toggle, edge-detect it into a one-cycle pulse, echo it as ack
    always_ff @(posedge clk_b or posedge rst_b) begin
      if (rst_b) begin
        req_sync_q <= '0;
        prev_q     <= 1'b0;
        imp_b_q    <= 1'b0;
      end else begin
        req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_t[ch]};
        prev_q     <= req_sync_q[SYNC_STAGES-1];
        imp_b_q    <= req_sync_q[SYNC_STAGES-1] ^ prev_q;
      end
    end

    assign req_t[ch]     = req_q;
    assign ack_t[ch]     = req_sync_q[SYNC_STAGES-1];
    assign busy_vec[ch]  = (state_q == S_WAIT);
    assign ovf_vec[ch]   = ovf_q;
    assign imp_b_vec[ch] = imp_b_q;
  end

  assign bus.busy_a = busy_vec;
  assign bus.ovf_a  = ovf_vec;
  assign bus.imp_b  = imp_b_vec;

endmodule

// File: tb/tb_cdc_pulse_sync_mc.sv
// Bench for cdc_pulse_sync_mc: vector table plus hand sequences, scoreboard of expected imp_b pulses.
`timescale 1ns/1ps
module tb_cdc_pulse_sync_mc;
  localparam int unsigned CH = 4;
`ifdef CDC_PULSE_DROP_ON_BUSY_EN
  localparam int CAP = 1;
`else
  localparam int CAP = 16;
`endif

  logic clk_a = 1'b0;
  logic clk_b = 1'b0;
  logic rst   = 1'b0;
  real  half_b = 13.5;

  always #5 clk_a = ~clk_a;
  always #(half_b) clk_b = ~clk_b;

  cdc_pulse_sync_mc_if #(.CHANNELS(CH)) bus ();

  cdc_pulse_sync_mc #(.CHANNELS(CH), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk_a (clk_a),
    .rst   (rst),
    .clk_b (clk_b),
    .bus   (bus)
  );

  typedef struct {
    logic [CH-1:0] mask;
    int            n;
    int            exp_del;
    logic [CH-1:0] exp_ovf;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  int            sb[$];
  int            delivered[CH];
  int            last_cyc[CH];
  int            cyc_b = 0;
  logic [CH-1:0] prev_b = '0;
  vec_t          vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // every imp_b pulse must be one cycle wide and match a scoreboard entry
  always @(negedge clk_b) begin
    int idx;
    cyc_b++;
    for (int c = 0; c < int'(CH); c++) begin
      if (bus.imp_b[c]) begin
        checks++;
        delivered[c]++;
        last_cyc[c] = cyc_b;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i] == c && idx < 0) idx = i;
        if (prev_b[c]) begin
          failures++;
          $display("FAIL imp_b_width ch%0d: high for 2+ clk_b cycles, expected 1", c);
        end else if (idx < 0) begin
          failures++;
          $display("FAIL imp_b_unexpected ch%0d: got pulse, expected none", c);
        end else begin
          sb.delete(idx);
        end
      end
    end
    prev_b = bus.imp_b;
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((bus.busy_a != '0 || sb.size() != 0) && n < 8000) begin
      @(posedge clk_a);
      n++;
    end
    checks++;
    if (n >= 8000) begin
      failures++;
      $display("FAIL %s_timeout: busy=%b pending=%0d, expected idle and 0", name, bus.busy_a, sb.size());
    end
    repeat (8) @(posedge clk_b);
  endtask

  task automatic drive(input logic [CH-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_a);
      bus.imp_a = mask;
      for (int c = 0; c < int'(CH); c++)
        if (mask[c] && k < CAP) sb.push_back(c);
    end
    @(negedge clk_a);
    bus.imp_a = '0;
  endtask

  task automatic clear_del();
    for (int c = 0; c < int'(CH); c++) delivered[c] = 0;
  endtask

  function automatic vec_t mk(input logic [CH-1:0] mask, input int n);
    vec_t v;
    v.mask    = mask;
    v.n       = n;
    v.exp_del = (n < CAP) ? n : CAP;
    v.exp_ovf = (n > CAP) ? mask : '0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lat;
    int         mx, mn;
    vecs[0] = mk(4'b0001, 1);
    vecs[1] = mk(4'b0010, 5);
    vecs[2] = mk(4'b1111, 1);
    vecs[3] = mk(4'b1000, 3);
    vecs[4] = mk(4'b0101, 2);
    vecs[5] = mk(4'b1010, 4);

    bus.imp_a   = '0;
    bus.ovf_clr = '0;
    #1   rst = 1'b1;
    #30.3;
    chk("reset_imp_b", 32'(bus.imp_b), 0);
    chk("reset_busy", 32'(bus.busy_a), 0);
    chk("reset_ovf", 32'(bus.ovf_a), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk_b);

    // table vectors
    for (int v = 0; v < 6; v++) begin
      clear_del();
      drive(vecs[v].mask, vecs[v].n);
      wait_done($sformatf("vec%0d", v));
      for (int c = 0; c < int'(CH); c++)
        chk($sformatf("vec%0d_del_ch%0d", v, c), 32'(delivered[c]),
            vecs[v].mask[c] ? 32'(vecs[v].exp_del) : 32'd0);
      chk($sformatf("vec%0d_ovf", v), 32'(bus.ovf_a), 32'(vecs[v].exp_ovf));
      @(negedge clk_a) bus.ovf_clr = '1;
      @(negedge clk_a) bus.ovf_clr = '0;
      chk($sformatf("vec%0d_ovf_clr", v), 32'(bus.ovf_a), 0);
    end

    // single-pulse latency: imp_b on the 3rd clk_b edge after the req toggle
    clear_del();
    @(negedge clk_a);
    bus.imp_a = 4'b0001;
    sb.push_back(0);
    @(posedge clk_a);
    #0.2 bus.imp_a = '0;
    chk("lat_busy", 32'(bus.busy_a), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_b);
      #0.2 lat[k] = bus.imp_b[0];
    end
    chk("lat_edges", 32'(lat), 32'(3'b100));
    wait_done("lat");
    chk("lat_del", 32'(delivered[0]), 1);

    // all channels at once: deliveries within one clk_b cycle of each other
    drive(4'b1111, 1);
    wait_done("all");
    mx = last_cyc[0];
    mn = last_cyc[0];
    for (int c = 1; c < int'(CH); c++) begin
      if (last_cyc[c] > mx) mx = last_cyc[c];
      if (last_cyc[c] < mn) mn = last_cyc[c];
    end
    chk("all_skew_le1", 32'(mx - mn <= 1), 1);

    // overflow and set-beats-clear, with a slow clk_b so no launch completes mid-burst
    half_b = 100.5;
    repeat (3) @(posedge clk_b);
    clear_del();
`ifdef CDC_PULSE_DROP_ON_BUSY_EN
    drive(4'b0001, 3);
    chk("drop_ovf", 32'(bus.ovf_a), 32'(4'b0001));
    bus.ovf_clr = 4'b0001;
    @(negedge clk_a);
    chk("drop_clr", 32'(bus.ovf_a), 0);
    bus.imp_a = 4'b0001;
    @(negedge clk_a);
    chk("drop_set_wins", 32'(bus.ovf_a), 32'(4'b0001));
    bus.imp_a   = '0;
    bus.ovf_clr = '0;
    wait_done("drop");
    chk("drop_del", 32'(delivered[0]), 1);
`else
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk_a);
      bus.imp_a = 4'b0100;
      sb.push_back(2);
    end
    @(negedge clk_a);
    chk("ovf_before_17", 32'(bus.ovf_a), 0);
    bus.imp_a = 4'b0100;
    @(negedge clk_a);
    chk("ovf_on_17", 32'(bus.ovf_a), 32'(4'b0100));
    bus.imp_a   = '0;
    bus.ovf_clr = 4'b0100;
    @(negedge clk_a);
    chk("ovf_clr", 32'(bus.ovf_a), 0);
    bus.imp_a = 4'b0100;
    @(negedge clk_a);
    chk("ovf_set_wins", 32'(bus.ovf_a), 32'(4'b0100));
    bus.imp_a   = '0;
    bus.ovf_clr = '0;
    wait_done("ovf");
    chk("ovf_del", 32'(delivered[2]), 16);
`endif
    @(negedge clk_a) bus.ovf_clr = '1;
    @(negedge clk_a) bus.ovf_clr = '0;
    half_b = 13.5;
    repeat (3) @(posedge clk_b);

    // reset mid-handshake with three pulses queued
    clear_del();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_a);
      bus.imp_a = 4'b0001;
      if (k < CAP) sb.push_back(0);
    end
    @(negedge clk_a);
    bus.imp_a = '0;
    chk("rst_busy_before", 32'(bus.busy_a), 1);
    #2.3 rst = 1'b1;
    #0.4;
    chk("rst_imp_b", 32'(bus.imp_b), 0);
    chk("rst_busy", 32'(bus.busy_a), 0);
    chk("rst_ovf", 32'(bus.ovf_a), 0);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i] == 0) sb.delete(i);
    #30 rst = 1'b0;
    repeat (20) @(posedge clk_b);
    chk("rst_no_pulse", 32'(delivered[0]), 0);
    chk("rst_idle", 32'(bus.busy_a), 0);
    drive(4'b0001, 1);
    wait_done("rst_after");
    chk("rst_after_del", 32'(delivered[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
